// File: rtl/stdp_update_scheduler.sv
// rtl/stdp_update_scheduler.sv - STDP weight-update scheduler over one shared datapath
//
// Purpose:
//   Sequences a single shared STDP weight-change datapath (one potentiation
//   unit, one depression unit, selected by dp_sel_neg) across NUM_SYN synapses
//   that converge on one postsynaptic neuron. Keeps the fixed-point simulation
//   clock, last-spike timestamps and the weight array. Each timestep issues one
//   depression per eligible presynaptic spike, then one potentiation per
//   eligible synapse on a postsynaptic spike, and writes back clamped weights.
//
// Optional feature:
//   STDP_TRACE_EN - adds trace_valid / trace_idx / trace_dw, pulsing in every
//                   writeback cycle with the unclamped datapath result.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   step              timestep strobe; spikes and dt are sampled with it
//   dt                timestep increment (Q format, positive)
//   pre_spike         presynaptic spikes, one bit per synapse
//   post_spike        postsynaptic spike
//   dp_t_change       time difference presented to the datapath
//   dp_sel_neg        1 = depression unit, 0 = potentiation unit
//   dp_weight_change  datapath result, combinational from dp_t_change
//   rd_idx, rd_weight combinational weight read port
//   busy              high while a timestep is being processed
//   done              one-cycle pulse in the commit cycle of a timestep
//   trace_*           writeback trace (STDP_TRACE_EN only)

module stdp_update_scheduler #(
  parameter int             N       = 32,
  parameter int             Q       = 16,
  parameter int             NUM_SYN = 4,
  parameter logic [N-1:0]   W_INIT  = 32'h0000_8000,
  parameter logic [N-1:0]   W_MIN   = 32'h0000_0000,
  parameter logic [N-1:0]   W_MAX   = 32'h0001_0000,
  localparam int            IW      = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic [N-1:0]       dt,
  input  logic [NUM_SYN-1:0] pre_spike,
  input  logic               post_spike,
  output logic [N-1:0]       dp_t_change,
  output logic               dp_sel_neg,
  input  logic [N-1:0]       dp_weight_change,
  input  logic [IW-1:0]      rd_idx,
  output logic [N-1:0]       rd_weight,
  output logic               busy,
  output logic               done
`ifdef STDP_TRACE_EN
  ,
  output logic               trace_valid,
  output logic [IW-1:0]      trace_idx,
  output logic [N-1:0]       trace_dw
`endif
);

  // The fractional point must sit inside the word.
  if (Q >= N) begin : g_bad_q
    $error("stdp_update_scheduler: Q must be smaller than N");
  end

  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_SYN - 1);
  localparam logic [N-1:0]    T_MAX    = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N:0] W_MIN_X = {W_MIN[N-1], W_MIN};
  localparam logic signed [N:0] W_MAX_X = {W_MAX[N-1], W_MAX};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEP_ISSUE,
    S_DEP_WB,
    S_POT_ISSUE,
    S_POT_WB,
    S_COMMIT
  } state_t;

  state_t             state;
  logic [IW-1:0]      idx;

  logic [N-1:0]       weight   [NUM_SYN];
  logic [N-1:0]       last_pre [NUM_SYN];
  logic [NUM_SYN-1:0] last_pre_vld;
  logic [N-1:0]       last_post;
  logic               last_post_vld;
  logic [N-1:0]       t_now;

  // Timestep being processed.
  logic [NUM_SYN-1:0] pre_l;
  logic               post_l;
  logic [N-1:0]       dt_l;

  // Single-entry buffer for a step that arrives while busy.
  logic               pending;
  logic [NUM_SYN-1:0] pend_pre;
  logic               pend_post;
  logic [N-1:0]       pend_dt;

  logic               idx_last;
  logic               dep_elig;
  logic               pot_elig;
  logic signed [N:0]  wb_sum;
  logic [N-1:0]       wb_clamped;
  logic [N:0]         t_sum;
  logic [N-1:0]       t_next;

  always_comb begin
    idx_last = (idx == LAST_IDX);
    dep_elig = pre_l[idx] && last_post_vld;
    pot_elig = post_l && last_pre_vld[idx];

    // Sign-extended add so an overflowing sum still clamps the right way.
    wb_sum = $signed({weight[idx][N-1], weight[idx]})
           + $signed({dp_weight_change[N-1], dp_weight_change});
    if (wb_sum < W_MIN_X) begin
      wb_clamped = W_MIN;
    end else if (wb_sum > W_MAX_X) begin
      wb_clamped = W_MAX;
    end else begin
      wb_clamped = wb_sum[N-1:0];
    end

    // The clock never goes negative; once it saturates it stays there.
    t_sum = {1'b0, t_now} + {1'b0, dt_l};
    if (t_sum > {1'b0, T_MAX}) begin
      t_next = T_MAX;
    end else begin
      t_next = t_sum[N-1:0];
    end
  end

  always_comb begin
    rd_weight = '0;
    if (int'(rd_idx) < NUM_SYN) begin
      rd_weight = weight[rd_idx];
    end
  end

`ifdef STDP_TRACE_EN
  // dp_weight_change is only meaningful while its issue result is held,
  // which is exactly the writeback cycle.
  always_comb begin
    trace_valid = (state == S_DEP_WB) || (state == S_POT_WB);
    trace_idx   = idx;
    trace_dw    = dp_weight_change;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      for (int i = 0; i < NUM_SYN; i++) begin
        weight[i]   <= W_INIT;
        last_pre[i] <= '0;
      end
      last_pre_vld  <= '0;
      last_post     <= '0;
      last_post_vld <= 1'b0;
      t_now         <= '0;
      pre_l         <= '0;
      post_l        <= 1'b0;
      dt_l          <= '0;
      pending       <= 1'b0;
      pend_pre      <= '0;
      pend_post     <= 1'b0;
      pend_dt       <= '0;
      dp_t_change   <= '0;
      dp_sel_neg    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;

      // Any step outside IDLE (including the commit cycle) is buffered;
      // repeated steps merge their spikes and keep the newest dt.
      if (step && (state != S_IDLE)) begin
        pending   <= 1'b1;
        pend_pre  <= (pending ? pend_pre : '0) | pre_spike;
        pend_post <= (pending & pend_post) | post_spike;
        pend_dt   <= dt;
      end

      case (state)
        S_IDLE: begin
          if (step || pending) begin
            pre_l   <= (pending ? pend_pre : '0) | (step ? pre_spike : '0);
            post_l  <= (pending & pend_post) | (step & post_spike);
            dt_l    <= step ? dt : pend_dt;
            pending <= 1'b0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_DEP_ISSUE;
          end
        end

        S_DEP_ISSUE: begin
          if (dep_elig) begin
            dp_sel_neg  <= 1'b1;
            dp_t_change <= t_now - last_post;
            state       <= S_DEP_WB;
          end else if (idx_last) begin
            idx   <= '0;
            state <= S_POT_ISSUE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_DEP_WB: begin
          weight[idx] <= wb_clamped;
          if (idx_last) begin
            idx   <= '0;
            state <= S_POT_ISSUE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_DEP_ISSUE;
          end
        end

        S_POT_ISSUE: begin
          if (pot_elig) begin
            dp_sel_neg  <= 1'b0;
            dp_t_change <= t_now - last_pre[idx];
            state       <= S_POT_WB;
          end else if (idx_last) begin
            done  <= 1'b1;
            state <= S_COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_POT_WB: begin
          weight[idx] <= wb_clamped;
          if (idx_last) begin
            done  <= 1'b1;
            state <= S_COMMIT;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_POT_ISSUE;
          end
        end

        S_COMMIT: begin
          // Timestamps move only here, so every pairing above saw the
          // previous spike times and t_change stays non-negative.
          for (int i = 0; i < NUM_SYN; i++) begin
            if (pre_l[i]) begin
              last_pre[i]     <= t_now;
              last_pre_vld[i] <= 1'b1;
            end
          end
          if (post_l) begin
            last_post     <= t_now;
            last_post_vld <= 1'b1;
          end
          t_now <= t_next;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
